// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one registered ALU among NUM_REQ requesters and
// returns ID-tagged results (or errors) over a valid/ready response channel.
//
// state | meaning
// IDLE  | arbitrate, accept one request, capture operands/opcode/ID
// ISSUE | pulse alu_enable for one cycle
// WAIT  | wait for alu_data_valid, bounded by the timeout down-counter
// RESP  | hold the response until rsp_ready
module alu_rr_scheduler #(
   parameter int N       = 8,
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 8,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ*N-1:0]   req_a_i,
   input  logic [NUM_REQ*N-1:0]   req_b_i,
   input  logic [NUM_REQ*4-1:0]   req_op_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [IDW-1:0]         rsp_id_o,
   output logic [2*N-1:0]         rsp_result_o,
   output logic                   rsp_err_o,
   output logic                   alu_enable_o,
   output logic [3:0]             alu_op_o,
   output logic [N-1:0]           alu_a_o,
   output logic [N-1:0]           alu_b_o,
   input  logic [2*N-1:0]         alu_result_i,
   input  logic                   alu_data_valid_i,
   output logic                   busy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic [3:0]     op_q, op_d;
   logic [2*N-1:0] result_q, result_d;
   logic           err_q, err_d;
   logic [TW-1:0]  tmo_q, tmo_d;

   logic [N-1:0]   a_arr  [NUM_REQ];
   logic [N-1:0]   b_arr  [NUM_REQ];
   logic [3:0]     op_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g]  = req_a_i[g*N +: N];
      assign b_arr[g]  = req_b_i[g*N +: N];
      assign op_arr[g] = req_op_i[g*4 +: 4];
   end

   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] cand_idx;
   int             cand;

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin : arbiter
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand     = (int'(ptr_q) + k) % NUM_REQ;
         cand_idx = IDW'(cand);
         if (!grant_found && req_valid_i[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   logic [3:0] sel_op;
   logic       sel_illegal;

   assign sel_op      = op_arr[grant_idx];
   assign sel_illegal = (sel_op == 4'b0011) || (sel_op == 4'b1110) || (sel_op == 4'b1111);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin : fsm
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      req_ready_o = '0;
      case (state_q)
         ST_IDLE: begin
            // Gated by rst so no grant is offered while reset is held.
            if (rst && grant_found) begin
               req_ready_o[grant_idx] = 1'b1;
               ptr_d    = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
               id_d     = grant_idx;
               a_d      = a_arr[grant_idx];
               b_d      = b_arr[grant_idx];
               op_d     = sel_op;
               result_d = '0;
               err_d    = sel_illegal;
               state_d  = sel_illegal ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tmo_d   = TW'(TIMEOUT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (alu_data_valid_i) begin
               result_d = alu_result_i;
               err_d    = 1'b0;
               tmo_d    = '0;
               state_d  = ST_RESP;
            end else if (tmo_q == '0) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = ST_RESP;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   logic alu_show;

   assign alu_show     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign alu_enable_o = (state_q == ST_ISSUE);
   assign alu_op_o     = alu_show ? op_q : 4'b0000;
   assign alu_a_o      = alu_show ? a_q : '0;
   assign alu_b_o      = alu_show ? b_q : '0;

   assign rsp_valid_o  = (state_q == ST_RESP);
   assign rsp_id_o     = rsp_valid_o ? id_q : '0;
   assign rsp_result_o = rsp_valid_o ? result_q : '0;
   assign rsp_err_o    = rsp_valid_o ? err_q : 1'b0;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: registered ALU model, cycle-level reference model of the
// round-robin service, and a response scoreboard fed at each accepted request.
module tb_alu_rr_scheduler;
   localparam int N   = 8;
   localparam int NR  = 4;
   localparam int TMO = 8;
   localparam int IDW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_ready;
   logic [NR*N-1:0] req_a = '0;
   logic [NR*N-1:0] req_b = '0;
   logic [NR*4-1:0] req_op = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [IDW-1:0]  rsp_id;
   logic [2*N-1:0]  rsp_result;
   logic            rsp_err;
   logic            alu_enable;
   logic [3:0]      alu_op;
   logic [N-1:0]    alu_a, alu_b;
   logic [2*N-1:0]  alu_result;
   logic            alu_dv;
   logic            busy;
   logic            alu_hang = 1'b0;

   alu_rr_scheduler #(.N(N), .NUM_REQ(NR), .TIMEOUT(TMO)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_a_i          (req_a),
      .req_b_i          (req_b),
      .req_op_i         (req_op),
      .rsp_valid_o      (rsp_valid),
      .rsp_ready_i      (rsp_ready),
      .rsp_id_o         (rsp_id),
      .rsp_result_o     (rsp_result),
      .rsp_err_o        (rsp_err),
      .alu_enable_o     (alu_enable),
      .alu_op_o         (alu_op),
      .alu_a_o          (alu_a),
      .alu_b_o          (alu_b),
      .alu_result_i     (alu_result),
      .alu_data_valid_i (alu_dv),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return {8'h00, a} + {8'h00, b};
         4'd1:    return {8'h00, a} - {8'h00, b};
         4'd2:    return 16'(a) * 16'(b);
         default: return {a ^ b, a | b} ^ {12'h000, op};
      endcase
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return (op == 4'd3) || (op == 4'd14) || (op == 4'd15);
   endfunction

   // ALU: one-cycle registered response, or none at all when hung
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_dv     <= 1'b0;
         alu_result <= '0;
      end else begin
         alu_dv <= alu_enable && !alu_hang;
         if (alu_enable) alu_result <= alu_fn(alu_op, alu_a, alu_b);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          id;
      logic [7:0]  a, b;
      logic [3:0]  op;
      logic        legal;
      logic        err;
      logic [15:0] res;
      int          acc;
      int          rsp_cyc;
   } exp_t;

   exp_t          q[$];
   exp_t          e;
   logic          mbusy = 1'b0;
   int            mptr = 0;
   logic [NR-1:0] last_grant = '0;
   logic [NR-1:0] exp_grant;
   logic          exp_en, exp_show, exp_rv;
   logic [19:0]   exp_ops;
   int            win;
   int            glog_id[$];
   int            glog_cyc[$];
   logic [IDW-1:0] last_id = '0;
   logic [15:0]   last_res = '0;
   logic          last_err = 1'b0;

   // Reference model + scoreboard, evaluated mid-cycle on stable values
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
                               alu_enable, alu_op, alu_a, alu_b, busy}, 64'h0);
         q.delete();
         mbusy      = 1'b0;
         mptr       = 0;
         last_grant = '0;
      end else begin
         exp_en   = 1'b0;
         exp_show = 1'b0;
         exp_rv   = 1'b0;
         exp_ops  = '0;
         if (mbusy) begin
            exp_en   = q[0].legal && (cyc == q[0].acc + 1);
            exp_show = q[0].legal && (cyc > q[0].acc) && (cyc < q[0].rsp_cyc);
            exp_rv   = (cyc >= q[0].rsp_cyc);
            if (exp_show) exp_ops = {q[0].op, q[0].a, q[0].b};
         end
         chk("busy", busy, mbusy);
         chk("alu_enable", alu_enable, exp_en);
         chk("alu_operands", {alu_op, alu_a, alu_b}, exp_ops);
         chk("rsp_valid", rsp_valid, exp_rv);
         if (exp_rv) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_result", rsp_result, q[0].res);
            chk("rsp_err", rsp_err, q[0].err);
         end

         exp_grant = '0;
         win = 0;
         if (!mbusy) begin
            for (int k = 0; k < NR; k++) begin
               int idx;
               idx = (mptr + k) % NR;
               if (exp_grant == '0 && req_valid[idx]) begin
                  exp_grant[idx] = 1'b1;
                  win = idx;
               end
            end
         end
         chk("req_ready", req_ready, exp_grant);
         last_grant = exp_grant;

         if (exp_grant != '0) begin
            e.id      = win;
            e.a       = req_a[win*N +: N];
            e.b       = req_b[win*N +: N];
            e.op      = req_op[win*4 +: 4];
            e.legal   = !is_illegal(e.op);
            e.err     = !e.legal || alu_hang;
            e.res     = e.err ? 16'h0000 : alu_fn(e.op, e.a, e.b);
            e.acc     = cyc;
            e.rsp_cyc = !e.legal ? cyc + 1 : (alu_hang ? cyc + 2 + TMO : cyc + 3);
            q.push_back(e);
            mbusy = 1'b1;
            mptr  = (win + 1) % NR;
            glog_id.push_back(win);
            glog_cyc.push_back(cyc);
         end else if (exp_rv && rsp_ready) begin
            last_id  = rsp_id;
            last_res = rsp_result;
            last_err = rsp_err;
            void'(q.pop_front());
            mbusy = 1'b0;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((busy || rsp_valid || q.size() != 0) && n < 100);
      chk("wait_idle_busy", busy, 1'b0);
   endtask

   task automatic issue(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      @(posedge clk);
      #1;
      req_a[id*N +: N]  = a;
      req_b[id*N +: N]  = b;
      req_op[id*4 +: 4] = op;
      req_valid[id]     = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[id] && n < 50);
      chk("issue_grant", req_ready[id], 1'b1);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   initial begin
      #300000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int n;
      logic [3:0] iops[3];

      // reset with every requester pending, then continuous fairness run
      for (int i = 0; i < NR; i++) begin
         req_a[i*N +: N]  = 8'(i * 17 + 3);
         req_b[i*N +: N]  = 8'(i * 29 + 5);
         req_op[i*4 +: 4] = (i == 3) ? 4'd4 : 4'(i);
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("first_grant", req_ready, 4'b0001);
      repeat (18) @(posedge clk);
      #1 req_valid = '0;
      wait_idle();
      chk("fair_count", glog_id.size(), 5);
      for (int i = 0; i < 5 && i < glog_id.size(); i++) begin
         chk("fair_order", glog_id[i], i % NR);
         if (i > 0) chk("fair_gap", glog_cyc[i] - glog_cyc[i-1], 4);
      end

      // single request
      issue(2, 4'b0000, 8'hFF, 8'h01);
      wait_idle();
      chk("single_id", last_id, 2);
      chk("single_result", last_res, 16'h0100);
      chk("single_err", last_err, 1'b0);

      // backpressure with other requesters waiting
      rsp_ready = 1'b0;
      issue(1, 4'b0010, 8'hFF, 8'hFF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 20);
      chk("bp_rsp_seen", rsp_valid, 1'b1);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) req_op[i*4 +: 4] = 4'd0;
      req_valid = 4'b1101;
      repeat (5) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      req_valid = '0;
      wait_idle();
      chk("bp_id", last_id, 1);
      chk("bp_result", last_res, 16'hFE01);
      chk("bp_err", last_err, 1'b0);

      // illegal opcodes
      iops[0] = 4'b0011;
      iops[1] = 4'b1110;
      iops[2] = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         issue(i, iops[i], 8'h12, 8'h34);
         wait_idle();
         chk("illegal_err", last_err, 1'b1);
         chk("illegal_result", last_res, 16'h0000);
      end

      // ALU never answers -> timeout error
      alu_hang = 1'b1;
      issue(3, 4'b0001, 8'h05, 8'h09);
      wait_idle();
      chk("timeout_id", last_id, 3);
      chk("timeout_err", last_err, 1'b1);
      chk("timeout_result", last_res, 16'h0000);

      // reset while waiting on the ALU
      issue(2, 4'b0000, 8'h01, 8'h02);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      alu_hang = 1'b0;
      req_op[2*4 +: 4] = 4'd0;
      req_op[3*4 +: 4] = 4'd1;
      req_valid = 4'b1100;
      rst = 1'b1;
      @(negedge clk);
      chk("ptr_after_reset", req_ready, 4'b0100);
      chk("no_rsp_after_reset", rsp_valid, 1'b0);
      @(posedge clk);
      #1 req_valid = '0;
      wait_idle();

      // randomized traffic with random backpressure
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (last_grant[i]) begin
               req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_a[i*N +: N]  = 8'($urandom);
                  req_b[i*N +: N]  = 8'($urandom);
                  req_op[i*4 +: 4] = 4'($urandom_range(0, 15));
                  req_valid[i]     = 1'b1;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
